// File: rtl/calc_host.sv
// calc_host: request/response front end that drives a command/data calculator device.
// Optional timeout watchdog on device waits is enabled by defining CALC_HOST_TIMEOUT_EN.
module calc_host #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          dev_cs,
  output logic [DW-1:0] dev_din,
  input  logic          dev_busy,
  input  logic          dev_drdy,
  input  logic [DW-1:0] dev_dout
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_DATA, ST_WAIT, ST_RD, ST_RSP
  } state_t;

  typedef enum logic [1:0] {
    P_OP2, P_OP1, P_TX
  } phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [1:0]    op, op_n;
  logic [DW-1:0] a, a_n;
  logic [DW-1:0] b, b_n;
  logic [DW-1:0] data_n;
  logic [DW-1:0] din_n;
  logic          tmo;

  function automatic logic [DW-1:0] cmd_byte(phase_t p, logic [1:0] o);
    logic [DW-1:0] c;
    c = '0;
    case (p)
      P_OP2: c = DW'(8'h08);
      P_OP1: begin
        case (o)
          2'd0:    c = DW'(8'h80);
          2'd1:    c = DW'(8'h40);
          2'd2:    c = DW'(8'h20);
          default: c = DW'(8'h10);
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign req_ready = (state == ST_IDLE) && !rst;

`ifdef CALC_HOST_TIMEOUT_EN
  logic [3:0] cnt;
  logic       err_n;

  // Fires on the edge at which the wait count would reach 15.
  assign tmo = (cnt == 4'd14);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt     <= (state_n != state) ? 4'd0 : cnt + 4'd1;
      rsp_err <= err_n;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    phase_n = phase;
    op_n    = op;
    a_n     = a;
    b_n     = b;
    data_n  = rsp_data;
`ifdef CALC_HOST_TIMEOUT_EN
    err_n   = rsp_err;
`endif
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_n    = req_op;
          a_n     = req_a;
          b_n     = req_b;
          phase_n = req_op[1] ? P_OP1 : P_OP2;
          state_n = ST_CMD;
        end
      end
      ST_CMD:  state_n = (phase == P_TX) ? ST_RD : ST_DATA;
      ST_DATA: state_n = ST_WAIT;
      ST_WAIT: begin
        if (!dev_busy) begin
          phase_n = (phase == P_OP2) ? P_OP1 : P_TX;
          state_n = ST_CMD;
        end else if (tmo) begin
          data_n  = '0;
`ifdef CALC_HOST_TIMEOUT_EN
          err_n   = 1'b1;
`endif
          state_n = ST_RSP;
        end
      end
      ST_RD: begin
        if (dev_drdy) begin
          data_n  = dev_dout;
`ifdef CALC_HOST_TIMEOUT_EN
          err_n   = 1'b0;
`endif
          state_n = ST_RSP;
        end else if (tmo) begin
          data_n  = '0;
`ifdef CALC_HOST_TIMEOUT_EN
          err_n   = 1'b1;
`endif
          state_n = ST_RSP;
        end
      end
      ST_RSP:  if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Device bus values are computed from the upcoming state so they are registered.
    din_n = '0;
    if (state_n == ST_CMD)
      din_n = cmd_byte(phase_n, op_n);
    else if (state_n == ST_DATA)
      din_n = (phase_n == P_OP2) ? b_n : a_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= P_OP2;
      op        <= '0;
      a         <= '0;
      b         <= '0;
      dev_cs    <= 1'b0;
      dev_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      op        <= op_n;
      a         <= a_n;
      b         <= b_n;
      dev_cs    <= (state_n == ST_CMD);
      dev_din   <= din_n;
      rsp_valid <= (state_n == ST_RSP);
      rsp_data  <= data_n;
    end
  end

endmodule

// File: tb/tb_calc_host.sv
// Directed testbench for calc_host with a behavioural calculator device model.
module tb_calc_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       dev_cs;
  logic [7:0] dev_din;
  logic       dev_busy;
  logic       dev_drdy;
  logic [7:0] dev_dout;

  int errs = 0;
  int checks = 0;

  logic       busy_hold = 1'b0;
  logic       drdy_stuck = 1'b0;
  logic [7:0] din_log [0:63];
  logic       cs_log  [0:63];

  calc_host #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dev_cs(dev_cs), .dev_din(dev_din),
    .dev_busy(dev_busy), .dev_drdy(dev_drdy), .dev_dout(dev_dout)
  );

  always #5 clk = ~clk;

  // Device: cs marks a command byte, the following cycle carries its operand.
  logic [7:0] d_cmd, d_op2, d_res;
  logic       d_exp, d_tx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_cmd <= '0; d_op2 <= '0; d_res <= '0;
      d_exp <= 1'b0; d_tx <= 1'b0;
      dev_busy <= 1'b0; dev_drdy <= 1'b0; dev_dout <= '0;
    end else begin
      dev_busy <= busy_hold;
      d_tx     <= 1'b0;
      dev_drdy <= d_tx && !drdy_stuck;
      dev_dout <= d_tx ? d_res : 8'h00;
      if (dev_cs) begin
        d_cmd <= dev_din;
        d_exp <= (dev_din != 8'h00);
        if (dev_din == 8'h00) d_tx <= 1'b1;
      end else if (d_exp) begin
        d_exp <= 1'b0;
        case (d_cmd)
          8'h08: d_op2 <= dev_din;
          8'h80: d_res <= dev_din + d_op2;
          8'h40: d_res <= dev_din - d_op2;
          8'h20: d_res <= d_res + dev_din;
          8'h10: d_res <= d_res - dev_din;
          default: ;
        endcase
      end
    end
  end

  // Issue one request from idle; lat = edges from acceptance to rsp_valid, -1 on timeout.
  task automatic issue(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int lat);
    int i;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    i = 0;
    while (lat < 0 && i < 60) begin
      din_log[i] = dev_din;
      cs_log[i]  = dev_cs;
      if (rsp_valid) lat = i;
      else begin
        @(posedge clk); #1;
      end
      i++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (dev_cs !== 1'b0) begin errs++; $display("FAIL rst_dev_cs got=%b exp=0", dev_cs); end
    checks++; if (dev_din !== 8'h00) begin errs++; $display("FAIL rst_dev_din got=%h exp=00", dev_din); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errs++; $display("FAIL rst_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    issue(2'd0, 8'h05, 8'h03, lat);
    checks++; if (lat !== 9) begin errs++; $display("FAIL add_latency got=%0d exp=9", lat); end
    checks++; if (rsp_data !== 8'h08) begin errs++; $display("FAIL add_data got=%h exp=08", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL add_err got=%b exp=0", rsp_err); end
    checks++; if ({cs_log[0], din_log[0]} !== {1'b1, 8'h08}) begin errs++; $display("FAIL add_seq0 got=%b/%h exp=1/08", cs_log[0], din_log[0]); end
    checks++; if ({cs_log[1], din_log[1]} !== {1'b0, 8'h03}) begin errs++; $display("FAIL add_seq1 got=%b/%h exp=0/03", cs_log[1], din_log[1]); end
    checks++; if ({cs_log[2], din_log[2]} !== {1'b0, 8'h00}) begin errs++; $display("FAIL add_wait got=%b/%h exp=0/00", cs_log[2], din_log[2]); end
    checks++; if ({cs_log[3], din_log[3]} !== {1'b1, 8'h80}) begin errs++; $display("FAIL add_seq2 got=%b/%h exp=1/80", cs_log[3], din_log[3]); end
    checks++; if ({cs_log[4], din_log[4]} !== {1'b0, 8'h05}) begin errs++; $display("FAIL add_seq3 got=%b/%h exp=0/05", cs_log[4], din_log[4]); end
    checks++; if ({cs_log[6], din_log[6]} !== {1'b1, 8'h00}) begin errs++; $display("FAIL add_seq4 got=%b/%h exp=1/00", cs_log[6], din_log[6]); end
    finish_rsp();
  endtask

  task automatic test_sub();
    int lat;
    issue(2'd1, 8'h02, 8'h05, lat);
    checks++; if (lat !== 9) begin errs++; $display("FAIL sub_latency got=%0d exp=9", lat); end
    checks++; if (rsp_data !== 8'hFD) begin errs++; $display("FAIL sub_data got=%h exp=fd", rsp_data); end
    checks++; if ({cs_log[3], din_log[3]} !== {1'b1, 8'h40}) begin errs++; $display("FAIL sub_cmd got=%b/%h exp=1/40", cs_log[3], din_log[3]); end
    finish_rsp();
  endtask

  task automatic test_acc();
    int lat;
    issue(2'd0, 8'h10, 8'h01, lat);
    checks++; if (rsp_data !== 8'h11) begin errs++; $display("FAIL acc_base got=%h exp=11", rsp_data); end
    finish_rsp();
    issue(2'd2, 8'h04, 8'hAA, lat);
    checks++; if (lat !== 6) begin errs++; $display("FAIL accadd_latency got=%0d exp=6", lat); end
    checks++; if (rsp_data !== 8'h15) begin errs++; $display("FAIL accadd_data got=%h exp=15", rsp_data); end
    checks++; if ({cs_log[0], din_log[0]} !== {1'b1, 8'h20}) begin errs++; $display("FAIL accadd_cmd got=%b/%h exp=1/20", cs_log[0], din_log[0]); end
    checks++; if ({cs_log[1], din_log[1]} !== {1'b0, 8'h04}) begin errs++; $display("FAIL accadd_opnd got=%b/%h exp=0/04", cs_log[1], din_log[1]); end
    finish_rsp();
    issue(2'd3, 8'h16, 8'h00, lat);
    checks++; if (lat !== 6) begin errs++; $display("FAIL accsub_latency got=%0d exp=6", lat); end
    checks++; if (rsp_data !== 8'hFF) begin errs++; $display("FAIL accsub_data got=%h exp=ff", rsp_data); end
    checks++; if (din_log[0] !== 8'h10) begin errs++; $display("FAIL accsub_cmd got=%h exp=10", din_log[0]); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    rsp_ready = 1'b0;
    issue(2'd1, 8'h09, 8'h04, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h05}) begin errs++; $display("FAIL stall_hold got=%b/%h exp=1/05", rsp_valid, rsp_data); end
      checks++; if (req_ready !== 1'b0) begin errs++; $display("FAIL stall_ready got=%b exp=0", req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL hs_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL hs_ready got=%b exp=1", req_ready); end
    issue(2'd0, 8'h01, 8'h01, lat);
    checks++; if (lat !== 9) begin errs++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
    checks++; if (rsp_data !== 8'h02) begin errs++; $display("FAIL b2b_data got=%h exp=02", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int lat;
    busy_hold = 1'b1;
    req_valid = 1'b1; req_op = 2'd0; req_a = 8'h07; req_b = 8'h07;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({dev_cs, dev_din, rsp_valid} !== 10'b0) begin errs++; $display("FAIL mid_wait got=%b/%h/%b exp=0/00/0", dev_cs, dev_din, rsp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (dev_cs !== 1'b0) begin errs++; $display("FAIL mid_rst_cs got=%b exp=0", dev_cs); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
    busy_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL mid_release_ready got=%b exp=1", req_ready); end
    issue(2'd0, 8'h20, 8'h22, lat);
    checks++; if (lat !== 9) begin errs++; $display("FAIL mid_next_latency got=%0d exp=9", lat); end
    checks++; if (rsp_data !== 8'h42) begin errs++; $display("FAIL mid_next_data got=%h exp=42", rsp_data); end
    finish_rsp();
  endtask

`ifdef CALC_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    drdy_stuck = 1'b1;
    issue(2'd0, 8'h01, 8'h02, lat);
    checks++; if (lat !== 22) begin errs++; $display("FAIL tmo_latency got=%0d exp=22", lat); end
    checks++; if (rsp_err !== 1'b1) begin errs++; $display("FAIL tmo_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_data !== 8'h00) begin errs++; $display("FAIL tmo_data got=%h exp=00", rsp_data); end
    drdy_stuck = 1'b0;
    finish_rsp();
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL tmo_idle got=%b exp=1", req_ready); end
    issue(2'd0, 8'h01, 8'h02, lat);
    checks++; if ({rsp_err, rsp_data} !== {1'b0, 8'h03}) begin errs++; $display("FAIL tmo_recover got=%b/%h exp=0/03", rsp_err, rsp_data); end
    finish_rsp();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog elapsed");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_back_to_back();
    test_reset_mid();
`ifdef CALC_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
